// File: rtl/rx_pack_pkg.sv
// Shared types and constants for the RX byte packer.
// Output word layout: {err, odd, last, data[15:0]}.
package rx_pack_pkg;

  localparam int W_OUT  = 19;
  localparam int ERR_B  = 18;
  localparam int ODD_B  = 17;
  localparam int LAST_B = 16;

  typedef enum logic [2:0] {
    IDLE,
    FRAME,
    DROP,
    TERM,
    SKIP
  } state_t;

  localparam logic [W_OUT-1:0] TERM_WORD =
    {1'b1, 1'b0, 1'b1, 16'h0000};

  function automatic logic [W_OUT-1:0] mk_word(
    input logic        err,
    input logic        odd,
    input logic        last,
    input logic [15:0] data
  );
    return {err, odd, last, data};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter, synchronous clear on rst_n.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // count one per inc pulse, stop at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_byte_packer.sv
// Packs MAC RX bytes into 19-bit flagged words; aborts on overflow.
// RX_PACK_STATS_EN enables frame_cnt/drop_cnt (else tied to 0).
module rx_byte_packer
  import rx_pack_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_last,
  input  logic             rx_error,
  output logic [W_OUT-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t           state;
  logic             have_lo;
  logic [7:0]       lo_byte;
  logic             term_pend;
  logic             slot_free;
  logic             xfer;
  logic             word_done;
  logic [W_OUT-1:0] word_in;

  assign xfer      = data_out_valid & data_out_ready;
  assign slot_free = ~data_out_valid | data_out_ready;
  assign word_done = have_lo | rx_last;

  // word completed by the current byte; lone byte goes low
  always_comb begin
    word_in = mk_word(
      rx_last & rx_error,
      rx_last & ~have_lo,
      rx_last,
      have_lo ? {rx_data, lo_byte} : {8'h00, rx_data}
    );
  end

  // packer FSM and the single registered output slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      have_lo        <= 1'b0;
      lo_byte        <= 8'h00;
      term_pend      <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (xfer) data_out_valid <= 1'b0;
      unique case (state)
        IDLE, FRAME: begin
          if (rx_valid) begin
            if (word_done) begin
              have_lo <= 1'b0;
              if (slot_free) begin
                data_out       <= word_in;
                data_out_valid <= 1'b1;
                state <= rx_last ? IDLE : FRAME;
              end else begin
                state <= rx_last ? TERM : DROP;
              end
            end else begin
              lo_byte <= rx_data;
              have_lo <= 1'b1;
              state   <= FRAME;
            end
          end
        end
        DROP: begin
          if (rx_valid && rx_last) state <= TERM;
        end
        TERM: begin
          if (slot_free) begin
            data_out       <= TERM_WORD;
            data_out_valid <= 1'b1;
          end
          if (rx_valid && !rx_last) begin
            state     <= SKIP;
            term_pend <= ~slot_free;
          end else if (slot_free) begin
            state <= IDLE;
          end
        end
        SKIP: begin
          if (term_pend && slot_free) begin
            data_out       <= TERM_WORD;
            data_out_valid <= 1'b1;
            term_pend      <= 1'b0;
          end
          if (rx_valid && rx_last) begin
            state <= (term_pend && !slot_free)
                   ? TERM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_PACK_STATS_EN
  logic drop_evt;
  logic good_evt;

  // a frame is lost on overflow or when it starts in TERM
  always_comb begin
    drop_evt = 1'b0;
    if (rx_valid) begin
      unique case (1'b1)
        (state == TERM):
          drop_evt = 1'b1;
        (state == IDLE) || (state == FRAME):
          drop_evt = word_done & ~slot_free;
        default:
          drop_evt = 1'b0;
      endcase
    end
  end

  assign good_evt = xfer & data_out[LAST_B]
                  & ~data_out[ERR_B];

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (good_evt),
    .cnt   (frame_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_evt),
    .cnt   (drop_cnt)
  );
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule
